dmd_bus_arb: RTL and testbench
==============================

DMD_BUS_ARB -- requirements
Module: dmd_bus_arb

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving the data bus width in bits.
REQ-002 The block SHALL have parameter NBANK, default 8, giving the number of memory read banks (range 1..16).
REQ-003 The block SHALL have parameter NSTL, default 4, giving the number of DMA steal requesters (range 1..8).
REQ-004 The block SHALL have parameter BURST, default 4, giving the maximum consecutive grant cycles per steal requester (range 1..15).
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset, with ports as follows:
- DSPCLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- bank_oe  in  NBANK  one-hot read enables, bit i = bank i.
- bank_rd  in  NBANK*DW  bank read data, bank i at [i*DW +: DW].
- core_dmd_do  in  DW  core DM write data (pre-ORed sources).
- core_pmd_do  in  DW  core PM write data.
- SREQ, GO_Cx, Pwrite_Ei, redoSTI_h  in  1 each  store-retry controls.
- stl_req  in  NSTL  steal requests.
- stl_do  in  NSTL*DW  steal data, requester j at [j*DW +: DW].
- stl_gnt  out  NSTL  registered one-hot steal grant.
- DM_wd  out  DW  DM write bus.
- PM_wd  out  DW  PM write bus.
- DMDin  out  DW  registered DM read-back bus.
- redo_vld  out  1  retry register holds unconsumed data.
- oe_err  out  1  registered multi-hot bank_oe pulse.
- oe_err_cnt  out  8  saturating multi-hot event count.

Function
REQ-006 Steal arbitration SHALL be round-robin with registered grant: a request sampled at edge n yields stl_gnt at edge n+1 at the earliest, and at most one bit of stl_gnt SHALL be high.
REQ-007 The current grantee SHALL keep its grant while its request stays high and it has held the grant for fewer than BURST consecutive cycles; otherwise the next requester after the grantee in ascending modulo order SHALL be granted.
REQ-008 If only the expiring grantee is requesting, it SHALL be re-granted and its burst count SHALL restart at 1.
REQ-009 With no requests, stl_gnt SHALL be 0 and the round-robin pointer SHALL hold its value.
REQ-010 DM_wd SHALL equal the granted requester's stl_do when any stl_gnt bit is set; otherwise it SHALL equal core_dmd_do OR redo_out (combinational).
REQ-011 PM_wd SHALL equal core_pmd_do OR redo_out (combinational).
REQ-012 redo_out SHALL equal STD when redoSTI_h && redo_vld, and 0 otherwise.
REQ-013 STD (DW bits) SHALL capture (Pwrite_Ei ? core_pmd_do : core_dmd_do) at any edge where SREQ && GO_Cx, and redo_vld SHALL be set at that edge.
REQ-014 redo_vld SHALL clear at an edge where redoSTI_h && redo_vld holds and no capture occurs; when capture and consume coincide, the capture SHALL win and redo_vld SHALL stay 1.
REQ-015 DMDin SHALL be registered with 1-cycle latency: if exactly one bank_oe bit is set, it SHALL load that bank's data; if none is set, it SHALL load DM_wd; if more than one is set, it SHALL load the lowest-indexed set bank's data.
REQ-016 A multi-hot bank_oe SHALL assert oe_err for one cycle at the next edge and increment oe_err_cnt, saturating at 255.

Reset
REQ-017 On RST the block SHALL drive stl_gnt=0, round-robin pointer=0 (requester 0 wins first), burst count=0, STD=0, redo_vld=0, DMDin=0, oe_err=0 and oe_err_cnt=0.
REQ-018 RST SHALL take priority over every simultaneous event, including capture, grant, and read.
REQ-019 RST asserted during a steal burst SHALL drop the grant at that edge, with no carry-over of the burst count.

Structure
REQ-020 Parameter defaults and the burst-counter width constant SHALL live in the shared DSP package and be used by all bus blocks.
REQ-021 The round-robin arbiter SHALL be a sub-module named rr_steal_arb (parameters NSTL and BURST; ports DSPCLK, RST, req, gnt).
REQ-022 The read mux, the retry register and the error counter SHALL stay flat in dmd_bus_arb.

Verification
REQ-023 With stl_req=4'b0101 held for 10 cycles and BURST=4, the bench SHALL observe gnt0 for 4 cycles, gnt2 for 4 cycles, then gnt0, with DM_wd matching the grantee's stl_do each cycle.
REQ-024 With SREQ=GO_Cx=1, Pwrite_Ei=1 and core_pmd_do=16'hA5A5, then redoSTI_h=1 two cycles later, the bench SHALL observe PM_wd=16'hA5A5 OR core_pmd_do, with redo_vld falling the next cycle.
REQ-025 With capture and redoSTI_h in the same cycle, the bench SHALL observe redo_vld remaining 1 and STD updating to the new data.
REQ-026 With bank_oe=8'b0000_0100 and bank 2 data 16'h1234, the bench SHALL observe DMDin=16'h1234 one cycle later; with bank_oe=0 it SHALL observe DMDin=previous DM_wd.
REQ-027 With bank_oe=8'b0001_0010 for 300 cycles, the bench SHALL observe DMDin=bank 1 data, oe_err high every cycle, and oe_err_cnt saturated at 255.
REQ-028 With RST pulsed in the middle of a burst, the bench SHALL observe stl_gnt=0 at the next edge and requester 0 granted first afterward.

Source files
------------

// File: rtl/dmd_bus_arb_pkg.sv
// Shared DSP bus package: parameter defaults and common widths for the bus blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dmd_bus_arb_pkg;

  localparam int unsigned DW_DEF    = 16;  // data bus width
  localparam int unsigned NBANK_DEF = 8;   // memory read banks
  localparam int unsigned NSTL_DEF  = 4;   // DMA steal requesters
  localparam int unsigned BURST_DEF = 4;   // max consecutive grant cycles per requester

  // Burst counter width; holds any BURST in 1..15.
  localparam int unsigned BCNT_W    = 4;

endpackage

// File: rtl/rr_steal_arb.sv
// Round-robin DMA steal arbiter with per-grantee burst limit and registered one-hot grant.
// Latency: request sampled at edge n produces gnt at edge n+1 at the earliest.
// Backpressure: none; a requester simply waits (holds req) until it is granted.
//
// Ports: DSPCLK (clock), RST (sync active-high reset), req (steal requests), gnt (one-hot grant).
module rr_steal_arb
  import dmd_bus_arb_pkg::*;
#(
  parameter int unsigned NSTL  = NSTL_DEF,
  parameter int unsigned BURST = BURST_DEF
) (
  input  logic            DSPCLK,
  input  logic            RST,
  input  logic [NSTL-1:0] req,
  output logic [NSTL-1:0] gnt
);

  localparam int unsigned PW = (NSTL > 1) ? $clog2(NSTL) : 1;

  logic [NSTL-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;   // first requester to consider on the next search
  logic [BCNT_W-1:0] cnt_q, cnt_d;   // consecutive cycles the current grantee has held
  logic              hold;
  logic              found;
  int                idx;

  // gnt_q is one-hot, so ANDing with req tells whether the grantee still wants the bus.
  assign hold = (|(gnt_q & req)) && (cnt_q < BCNT_W'(BURST));

  always_comb begin
    gnt_d = '0;
    ptr_d = ptr_q;
    cnt_d = '0;
    found = 1'b0;
    idx   = 0;
    if (hold) begin
      gnt_d = gnt_q;
      cnt_d = cnt_q + BCNT_W'(1);
    end else begin
      // ptr_q always points just past the last grantee, so scanning NSTL slots from it
      // visits the expiring grantee last: it is re-granted only if nobody else asks.
      for (int i = 0; i < int'(NSTL); i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= int'(NSTL)) idx = idx - int'(NSTL);
        if (!found && req[idx]) begin
          found      = 1'b1;
          gnt_d[idx] = 1'b1;
          cnt_d      = BCNT_W'(1);
          ptr_d      = (idx + 1 == int'(NSTL)) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      gnt_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: rtl/dmd_bus_arb.sv
// DSP data-memory bus arbiter: steal arbitration, DM/PM write muxing, store-retry register, banked read-back.
// Latency: DM_wd/PM_wd combinational; stl_gnt, DMDin, redo_vld, oe_err, oe_err_cnt registered (1 cycle).
// Backpressure: none; steal requesters hold stl_req until granted, the core is never stalled here.
//
// Ports: DSPCLK/RST clock and sync reset; bank_oe/bank_rd banked read inputs; core_dmd_do/core_pmd_do
// core write data; SREQ/GO_Cx/Pwrite_Ei/redoSTI_h retry controls; stl_req/stl_do steal side;
// outputs stl_gnt, DM_wd, PM_wd, DMDin, redo_vld, oe_err, oe_err_cnt.
module dmd_bus_arb
  import dmd_bus_arb_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned NBANK = NBANK_DEF,
  parameter int unsigned NSTL  = NSTL_DEF,
  parameter int unsigned BURST = BURST_DEF
) (
  input  logic               DSPCLK,
  input  logic               RST,
  input  logic [NBANK-1:0]   bank_oe,
  input  logic [NBANK*DW-1:0] bank_rd,
  input  logic [DW-1:0]      core_dmd_do,
  input  logic [DW-1:0]      core_pmd_do,
  input  logic               SREQ,
  input  logic               GO_Cx,
  input  logic               Pwrite_Ei,
  input  logic               redoSTI_h,
  input  logic [NSTL-1:0]    stl_req,
  input  logic [NSTL*DW-1:0] stl_do,
  output logic [NSTL-1:0]    stl_gnt,
  output logic [DW-1:0]      DM_wd,
  output logic [DW-1:0]      PM_wd,
  output logic [DW-1:0]      DMDin,
  output logic               redo_vld,
  output logic               oe_err,
  output logic [7:0]         oe_err_cnt
);

  rr_steal_arb #(
    .NSTL  (NSTL),
    .BURST (BURST)
  ) u_arb (
    .DSPCLK (DSPCLK),
    .RST    (RST),
    .req    (stl_req),
    .gnt    (stl_gnt)
  );

  // ---------------- store-retry register ----------------
  logic [DW-1:0] std_q, std_d;
  logic          rvld_q, rvld_d;
  logic          capture, consume;
  logic [DW-1:0] redo_out;

  assign capture  = SREQ && GO_Cx;
  assign consume  = redoSTI_h && rvld_q;
  assign redo_out = consume ? std_q : '0;

  always_comb begin
    std_d  = std_q;
    rvld_d = rvld_q;
    if (capture) begin
      // A new capture overrides a same-cycle consume: the fresh data must survive.
      std_d  = Pwrite_Ei ? core_pmd_do : core_dmd_do;
      rvld_d = 1'b1;
    end else if (consume) begin
      rvld_d = 1'b0;
    end
  end

  // ---------------- write buses ----------------
  logic [DW-1:0] stl_mux;

  always_comb begin
    stl_mux = '0;
    for (int j = 0; j < int'(NSTL); j++) begin
      if (stl_gnt[j]) stl_mux = stl_mux | stl_do[j*DW +: DW];
    end
  end

  assign DM_wd = (|stl_gnt) ? stl_mux : (core_dmd_do | redo_out);
  assign PM_wd = core_pmd_do | redo_out;

  // ---------------- banked read-back ----------------
  logic [DW-1:0] rd_sel;
  logic          rd_hit;
  logic          oe_multi;
  logic [DW-1:0] dmdin_q, dmdin_d;
  logic          oe_err_q;
  logic [7:0]    oe_cnt_q, oe_cnt_d;

  // Lowest-indexed set bank wins; this also covers the legal one-hot case.
  always_comb begin
    rd_sel = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < int'(NBANK); i++) begin
      if (bank_oe[i] && !rd_hit) begin
        rd_sel = bank_rd[i*DW +: DW];
        rd_hit = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign oe_multi = |(bank_oe & (bank_oe - NBANK'(1)));
  assign dmdin_d  = rd_hit ? rd_sel : DM_wd;
  assign oe_cnt_d = (oe_multi && (oe_cnt_q != 8'hFF)) ? oe_cnt_q + 8'd1 : oe_cnt_q;

  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      std_q    <= '0;
      rvld_q   <= 1'b0;
      dmdin_q  <= '0;
      oe_err_q <= 1'b0;
      oe_cnt_q <= '0;
    end else begin
      std_q    <= std_d;
      rvld_q   <= rvld_d;
      dmdin_q  <= dmdin_d;
      oe_err_q <= oe_multi;
      oe_cnt_q <= oe_cnt_d;
    end
  end

  assign DMDin      = dmdin_q;
  assign redo_vld   = rvld_q;
  assign oe_err     = oe_err_q;
  assign oe_err_cnt = oe_cnt_q;

endmodule

// File: tb/tb_dmd_bus_arb.sv
// Bench for dmd_bus_arb: directed stimulus pushes cycle-tagged expectations, a negedge monitor checks them.
// Latency: expectations are tagged with the cycle in which the output must hold.
// Backpressure: n/a.
module tb_dmd_bus_arb;

  localparam int DW    = 16;
  localparam int NBANK = 8;
  localparam int NSTL  = 4;

  localparam int S_GNT   = 0;
  localparam int S_DMWD  = 1;
  localparam int S_PMWD  = 2;
  localparam int S_DMDIN = 3;
  localparam int S_RVLD  = 4;
  localparam int S_OEERR = 5;
  localparam int S_OECNT = 6;

  logic                DSPCLK = 1'b0;
  logic                RST;
  logic [NBANK-1:0]    bank_oe;
  logic [NBANK*DW-1:0] bank_rd;
  logic [DW-1:0]       core_dmd_do;
  logic [DW-1:0]       core_pmd_do;
  logic                SREQ, GO_Cx, Pwrite_Ei, redoSTI_h;
  logic [NSTL-1:0]     stl_req;
  logic [NSTL*DW-1:0]  stl_do;
  logic [NSTL-1:0]     stl_gnt;
  logic [DW-1:0]       DM_wd, PM_wd, DMDin;
  logic                redo_vld, oe_err;
  logic [7:0]          oe_err_cnt;

  always #5 DSPCLK = ~DSPCLK;

  dmd_bus_arb #(
    .DW    (DW),
    .NBANK (NBANK),
    .NSTL  (NSTL),
    .BURST (4)
  ) dut (
    .DSPCLK      (DSPCLK),
    .RST         (RST),
    .bank_oe     (bank_oe),
    .bank_rd     (bank_rd),
    .core_dmd_do (core_dmd_do),
    .core_pmd_do (core_pmd_do),
    .SREQ        (SREQ),
    .GO_Cx       (GO_Cx),
    .Pwrite_Ei   (Pwrite_Ei),
    .redoSTI_h   (redoSTI_h),
    .stl_req     (stl_req),
    .stl_do      (stl_do),
    .stl_gnt     (stl_gnt),
    .DM_wd       (DM_wd),
    .PM_wd       (PM_wd),
    .DMDin       (DMDin),
    .redo_vld    (redo_vld),
    .oe_err      (oe_err),
    .oe_err_cnt  (oe_err_cnt)
  );

  typedef struct {
    int          tgt;
    int          sig;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Hand-computed grant sequence for stl_req=0101, BURST=4, and the matching steal data.
  logic [3:0]  exp_gnt [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1};
  logic [15:0] exp_dm  [10] = '{16'hA000, 16'hA000, 16'hA000, 16'hA000,
                                16'hC222, 16'hC222, 16'hC222, 16'hC222,
                                16'hA000, 16'hA000};

  always @(posedge DSPCLK) cyc <= cyc + 1;

  task automatic push(input int dly, input int sig, input logic [15:0] val, input string name);
    exp_t e;
    e.tgt  = cyc + dly;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge DSPCLK);
    #1;
  endtask

  function automatic logic [15:0] actual(input int sig);
    case (sig)
      S_GNT:   return {12'h000, stl_gnt};
      S_DMWD:  return DM_wd;
      S_PMWD:  return PM_wd;
      S_DMDIN: return DMDin;
      S_RVLD:  return {15'h0000, redo_vld};
      S_OEERR: return {15'h0000, oe_err};
      S_OECNT: return {8'h00, oe_err_cnt};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: every cycle, retire the expectations tagged for this cycle.
  always @(negedge DSPCLK) begin
    int mi;
    logic [15:0] got;
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].tgt == cyc) begin
        n_tests++;
        got = actual(sb[mi].sig);
        if (got !== sb[mi].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sb[mi].name, cyc, got, sb[mi].val);
        end
        sb.delete(mi);
      end else if (sb[mi].tgt < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s stale cyc=%0d tgt=%0d", sb[mi].name, cyc, sb[mi].tgt);
        sb.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    RST         = 1'b1;
    bank_oe     = '0;
    core_dmd_do = '0;
    core_pmd_do = '0;
    SREQ        = 1'b0;
    GO_Cx       = 1'b0;
    Pwrite_Ei   = 1'b0;
    redoSTI_h   = 1'b0;
    stl_req     = '0;
    stl_do      = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
    for (int i = 0; i < NBANK; i++) bank_rd[i*DW +: DW] = {8'(i), 8'hC0};
    bank_rd[1*DW +: DW] = 16'h5A01;
    bank_rd[2*DW +: DW] = 16'h1234;

    // Reset state
    step();
    push(0, S_GNT,   16'h0, "rst_gnt");
    push(0, S_DMDIN, 16'h0, "rst_dmdin");
    push(0, S_RVLD,  16'h0, "rst_rvld");
    push(0, S_OEERR, 16'h0, "rst_oe_err");
    push(0, S_OECNT, 16'h0, "rst_oe_cnt");
    RST = 1'b0;
    step();

    // Round-robin bursts: requesters 0 and 2
    push(0, S_GNT, 16'h0, "gnt_before_req");
    stl_req = 4'b0101;
    for (int k = 0; k < 10; k++) begin
      push(k + 1, S_GNT,  16'(exp_gnt[k]), "rr_gnt");
      push(k + 1, S_DMWD, exp_dm[k],       "rr_dm_wd");
    end
    push(2, S_DMDIN, 16'hA000, "dmdin_from_steal");
    repeat (10) step();
    stl_req = '0;
    push(1, S_GNT,  16'h0, "gnt_release");
    push(1, S_DMWD, 16'h0, "dm_wd_idle");
    step();

    // Reset in the middle of a burst
    stl_req = 4'b1000;
    push(1, S_GNT, 16'h8, "gnt3");
    step();
    step();
    RST     = 1'b1;
    stl_req = 4'b1001;
    push(1, S_GNT,   16'h0, "rst_mid_burst_gnt");
    push(1, S_DMDIN, 16'h0, "rst_mid_burst_dmdin");
    step();
    RST = 1'b0;
    push(1, S_GNT,  16'h1, "post_rst_gnt0");
    push(1, S_DMWD, 16'hA000, "post_rst_dm_wd");
    step();
    stl_req = '0;
    push(1, S_GNT, 16'h0, "post_rst_release");
    step();
    step();

    // Store retry: PM capture, then consume two cycles later
    Pwrite_Ei   = 1'b1;
    core_pmd_do = 16'hA5A5;
    SREQ        = 1'b1;
    GO_Cx       = 1'b1;
    push(1, S_RVLD, 16'h1, "cap_rvld");
    step();
    SREQ        = 1'b0;
    GO_Cx       = 1'b0;
    core_pmd_do = 16'h0000;
    push(0, S_PMWD, 16'h0000, "pm_wd_no_consume");
    step();
    redoSTI_h   = 1'b1;
    core_pmd_do = 16'h0F0F;
    push(0, S_PMWD,  16'hAFAF, "pm_wd_redo");
    push(0, S_DMWD,  16'hA5A5, "dm_wd_redo");
    push(1, S_RVLD,  16'h0,    "consume_rvld");
    push(1, S_DMDIN, 16'hA5A5, "dmdin_from_dm_wd");
    step();
    redoSTI_h = 1'b0;
    push(0, S_PMWD, 16'h0F0F, "pm_wd_after_consume");
    step();

    // Capture and consume in the same cycle
    core_pmd_do = 16'h0000;
    Pwrite_Ei   = 1'b0;
    core_dmd_do = 16'h1111;
    SREQ        = 1'b1;
    GO_Cx       = 1'b1;
    push(1, S_RVLD, 16'h1, "cap2_rvld");
    step();
    core_dmd_do = 16'h2222;
    redoSTI_h   = 1'b1;
    push(0, S_DMWD,  16'h3333, "dm_wd_cap_and_redo");
    push(1, S_RVLD,  16'h1,    "cap_wins_rvld");
    push(1, S_DMDIN, 16'h3333, "dmdin_cap_and_redo");
    step();
    SREQ        = 1'b0;
    GO_Cx       = 1'b0;
    core_dmd_do = 16'h0000;
    push(0, S_DMWD, 16'h2222, "std_updated_dm");
    push(0, S_PMWD, 16'h2222, "std_updated_pm");
    push(1, S_RVLD, 16'h0,    "consume2_rvld");
    step();
    redoSTI_h = 1'b0;
    push(0, S_DMWD, 16'h0000, "dm_wd_quiet");
    step();

    // One-hot bank read, then no bank
    bank_oe = 8'b0000_0100;
    push(1, S_DMDIN, 16'h1234, "bank2_read");
    push(1, S_OEERR, 16'h0,    "onehot_no_err");
    step();
    bank_oe     = '0;
    core_dmd_do = 16'h00C3;
    push(1, S_DMDIN, 16'h00C3, "no_bank_dm_wd");
    step();
    core_dmd_do = '0;

    // Multi-hot for 300 cycles: lowest bank wins, counter saturates
    bank_oe = 8'b0001_0010;
    for (int k = 1; k <= 300; k++) begin
      push(k, S_DMDIN, 16'h5A01, "multihot_dmdin");
      push(k, S_OEERR, 16'h1,    "multihot_err");
      push(k, S_OECNT, 16'((k > 255) ? 255 : k), "multihot_cnt");
    end
    repeat (300) step();
    bank_oe = '0;
    push(1, S_OEERR, 16'h0,  "err_clear");
    push(1, S_OECNT, 16'hFF, "cnt_held");
    step();

    for (int w = 0; w < 5 && sb.size() > 0; w++) step();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
